emaxi_read_arbiter: RTL
=======================

EMAXI_READ_ARBITER -- requirements
Module: emaxi_read_arbiter

Interface
REQ-001 Parameter MAX_OUTST, default 4: maximum outstanding bursts per requester (1..7).
REQ-002 Parameter ID_BASE, default 12'h000: base ARID; requester n uses ID_BASE|n.
REQ-003 clk  in  1  single clock, all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rq_valid[1:0], rq_ready[1:0]  in/out  1 each  per-requester read-request handshake.
REQ-006 rq_araddr_n / rq_arlen_n / rq_arsize_n / rq_arburst_n (n=0,1)  in  32/8/3/2  request fields.
REQ-007 m_axi_arid / araddr / arlen / arsize / arburst  out  12/32/8/3/2  AR channel, registered.
REQ-008 m_axi_arvalid out 1, m_axi_arready in 1  AR handshake.
REQ-009 m_axi_rid / rdata / rresp / rlast / rvalid  in  12/64/2/1/1; m_axi_rready out 1.
REQ-010 rs_valid[1:0] out, rs_ready[1:0] in, rs_data / rs_resp / rs_last  out  64/2/1 shared  routed response.
REQ-011 rid_err  out  1  sticky flag: response with unknown RID seen.

Function
REQ-012 AR FSM states IDLE, ISSUE; reset to IDLE.
REQ-013 IDLE: eligible = rq_valid[n] & (outst[n] < MAX_OUTST); if any eligible, grant by round-robin, pulse rq_ready[n] same cycle, latch fields, go ISSUE.
REQ-014 Round-robin: last_grant reg (reset 1, so requester 0 wins first tie); on tie, grant !last_grant; update last_grant on grant.
REQ-015 ISSUE: m_axi_arvalid=1, fields stable; on arready go IDLE; no new grant in the arready cycle (one-cycle bubble, max 1 AR per 2 cycles).
REQ-016 Latency: rq_valid&rq_ready at cycle t -> m_axi_arvalid high at t+1.
REQ-017 rq_ready SHALL be 0 in ISSUE and for non-eligible requesters.
REQ-018 outst[n] 3-bit counter: +1 on AR handshake with arid[0]=n; -1 on R beat with rlast & rvalid & rready routed to n; simultaneous +1/-1 leaves it unchanged; never wraps.
REQ-019 R routing: rid == ID_BASE|n -> rs_valid[n]=m_axi_rvalid, m_axi_rready=rs_ready[n]; combinational pass-through, zero latency.
REQ-020 rid not matching either ID: m_axi_rready=1 (beat dropped), rs_valid=0, rid_err set next cycle, held until rst.
REQ-021 rs_data/resp/last driven from m_axi_r* unconditionally.
REQ-022 Outstanding decrement on R beat SHALL occur even while AR FSM in ISSUE.

Reset
REQ-023 On rst: state IDLE, m_axi_arvalid=0, ar fields 0, outst[0..1]=0, last_grant=1, rid_err=0.
REQ-024 rst mid-ISSUE drops pending AR (arvalid low next cycle); in-flight R beats after reset are rid-routed normally but do not decrement zero counters.
REQ-025 rq_ready, rs_valid SHALL be 0 in any cycle with rst=1.

Structure
REQ-026 Shared package emaxi_pkg: AR field widths (ADDR_W=32, ID_W=12, LEN_W=8), burst encodings (FIXED/INCR/WRAP), FSM state enum.
REQ-027 One sub-module emaxi_outst_cnt (saturating up/down counter with full flag), instantiated twice.

Verification
REQ-028 Both rq_valid=1 from reset, arready=1 -> grants 0,1,0,1 alternate; arid 12'h000,12'h001; AR every 2 cycles.
REQ-029 rq_valid[0]=1 at t, arready held 0 for 5 cycles -> arvalid high t+1..t+6, araddr constant, rq_ready[0]=0 throughout.
REQ-030 Requester 0 issues 4 ARs, no R -> 5th request blocked (rq_ready[0]=0) while requester 1 still granted; one rlast beat rid=0 -> requester 0 granted next IDLE.
REQ-031 AR handshake for id 0 same cycle as rlast beat for id 0 with outst[0]=2 -> outst[0] stays 2.
REQ-032 R beat rid=12'h005 -> m_axi_rready=1, rs_valid=2'b00, rid_err=1 from next cycle until rst.
REQ-033 rst asserted during ISSUE with arready=0 -> arvalid=0, outst=0, rid_err=0 next cycle.

Source files
------------

// File: rtl/emaxi_pkg.sv
// emaxi_pkg: shared AR-channel widths, burst encodings and read-arbiter FSM states
package emaxi_pkg;
  localparam int ADDR_W = 32;
  localparam int ID_W = 12;
  localparam int LEN_W = 8;
  localparam int SIZE_W = 3;
  localparam int BURST_W = 2;
  localparam int DATA_W = 64;
  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_e;
endpackage

// File: rtl/emaxi_outst_cnt.sv
// emaxi_outst_cnt: saturating up/down outstanding-burst counter with full flag
module emaxi_outst_cnt #(
  parameter int MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] cnt,
  output logic       full
);
  assign full = cnt >= 3'(MAX);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (inc && !dec && cnt != 3'd7) cnt <= cnt + 3'd1;
    else if (dec && !inc && cnt != 3'd0) cnt <= cnt - 3'd1;
  end
endmodule

// File: rtl/emaxi_read_arbiter.sv
// emaxi_read_arbiter: two-requester round-robin AXI read arbiter with RID-based response routing
module emaxi_read_arbiter
  import emaxi_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter logic [ID_W-1:0] ID_BASE = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         rq_valid,
  output logic [1:0]         rq_ready,
  input  logic [ADDR_W-1:0]  rq_araddr_0,
  input  logic [LEN_W-1:0]   rq_arlen_0,
  input  logic [SIZE_W-1:0]  rq_arsize_0,
  input  logic [BURST_W-1:0] rq_arburst_0,
  input  logic [ADDR_W-1:0]  rq_araddr_1,
  input  logic [LEN_W-1:0]   rq_arlen_1,
  input  logic [SIZE_W-1:0]  rq_arsize_1,
  input  logic [BURST_W-1:0] rq_arburst_1,
  output logic [ID_W-1:0]    m_axi_arid,
  output logic [ADDR_W-1:0]  m_axi_araddr,
  output logic [LEN_W-1:0]   m_axi_arlen,
  output logic [SIZE_W-1:0]  m_axi_arsize,
  output logic [BURST_W-1:0] m_axi_arburst,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [ID_W-1:0]    m_axi_rid,
  input  logic [DATA_W-1:0]  m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rlast,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  output logic [1:0]         rs_valid,
  input  logic [1:0]         rs_ready,
  output logic [DATA_W-1:0]  rs_data,
  output logic [1:0]         rs_resp,
  output logic               rs_last,
  output logic               rid_err
);
  ar_state_e state, state_nx;
  logic last_grant, gnt, any;
  logic [1:0] elig, full, inc, dec, match, route;
  always_comb begin
    elig = rq_valid & ~full;
    any = |elig;
    gnt = &elig ? ~last_grant : elig[1];
    state_nx = state == IDLE ? (any ? ISSUE : IDLE) : (m_axi_arready ? IDLE : ISSUE);
    rq_ready = (state == IDLE && any && !rst) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      m_axi_arid <= '0;
      m_axi_araddr <= '0;
      m_axi_arlen <= '0;
      m_axi_arsize <= '0;
      m_axi_arburst <= '0;
      rid_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        last_grant <= gnt;
        m_axi_arid <= ID_BASE | ID_W'(gnt);
        m_axi_araddr <= gnt ? rq_araddr_1 : rq_araddr_0;
        m_axi_arlen <= gnt ? rq_arlen_1 : rq_arlen_0;
        m_axi_arsize <= gnt ? rq_arsize_1 : rq_arsize_0;
        m_axi_arburst <= gnt ? rq_arburst_1 : rq_arburst_0;
      end
      if (m_axi_rvalid && match == 2'b00) rid_err <= 1'b1;
    end
  end
  assign m_axi_arvalid = state == ISSUE;
  // last_grant always names the requester whose AR is currently being issued
  assign match = {m_axi_rid == (ID_BASE | ID_W'(1)), m_axi_rid == ID_BASE};
  assign route = {match[1] & ~match[0], match[0]};
  assign m_axi_rready = match[0] ? rs_ready[0] : match[1] ? rs_ready[1] : 1'b1;
  assign rs_valid = rst ? 2'b00 : route & {2{m_axi_rvalid}};
  assign rs_data = m_axi_rdata;
  assign rs_resp = m_axi_rresp;
  assign rs_last = m_axi_rlast;
  assign inc = {2{m_axi_arvalid & m_axi_arready}} & {last_grant, ~last_grant};
  assign dec = {2{m_axi_rvalid & m_axi_rlast & m_axi_rready}} & route;
  for (genvar i = 0; i < 2; i++) begin : g_cnt
    emaxi_outst_cnt #(.MAX(MAX_OUTST)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(inc[i]),
      .dec(dec[i]),
      .cnt(),
      .full(full[i])
    );
  end
endmodule
